load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 31 +++
 rtl/lsu_load_align.sv | 28 ++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: default widths,
// RV32I funct3 size codes, FSM states and a legality helper.
package load_store_unit_pkg;

    localparam int DEF_DATA_SIZE = 32;
    localparam int DEF_ADDR_SIZE = 32;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Stores only exist in signed-code form (SB/SH/SW).
    function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !wr;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction and sign/zero extension (combinational).
module lsu_load_align
    import load_store_unit_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic [2:0]           i_funct3,
    input  logic [1:0]           i_offset,
    input  logic [DATA_SIZE-1:0] i_rdata,
    output logic [DATA_SIZE-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_offset, 3'b000} +: 8];
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{(DATA_SIZE-8){w_byte[7]}}, w_byte};
            F3_BU:   o_data = {{(DATA_SIZE-8){1'b0}}, w_byte};
            F3_H:    o_data = {{(DATA_SIZE-16){w_half[15]}}, w_half};
            F3_HU:   o_data = {{(DATA_SIZE-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit, IDLE -> BUSY -> DONE.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0] req_wdata,
    input  logic [4:0]           req_rd,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic                 mem_we,
    output logic [ADDR_SIZE-3:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic                 wb_valid,
    output logic [4:0]           wb_rd,
    output logic [DATA_SIZE-1:0] wb_data,
    output logic                 store_done,
    output logic                 access_err
);

    state_e               r_state;
    logic                 r_we;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [DATA_SIZE-1:0] r_wdata;
    logic [3:0]           r_wstrb;
    logic [2:0]           r_f3;
    logic [4:0]           r_rd;
    logic [DATA_SIZE-1:0] r_wb_data;
    logic                 r_req_ready;
    logic                 r_mem_req;
    logic                 r_wb_valid;
    logic                 r_store_done;
    logic                 r_err;

    logic                 w_ok;
    logic [ADDR_SIZE-1:0] w_addr;
    logic [DATA_SIZE-1:0] w_wdata;
    logic [3:0]           w_wstrb;
    logic [DATA_SIZE-1:0] w_load_data;

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_mis;
    assign w_mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign w_ok  = f3_legal(req_write, req_funct3) && !w_mis;
`else
    assign w_ok  = f3_legal(req_write, req_funct3);
`endif

    // Low address bits below the access size are dropped before issue.
    always_comb begin
        w_addr  = req_addr;
        w_wdata = req_wdata;
        w_wstrb = 4'b0000;
        case (req_funct3[1:0])
            2'b00: begin
                w_wdata = DATA_SIZE'({4{req_wdata[7:0]}});
                w_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                w_addr[0] = 1'b0;
                w_wdata   = DATA_SIZE'({2{req_wdata[15:0]}});
                w_wstrb   = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_addr[1:0] = 2'b00;
                w_wstrb     = 4'b1111;
            end
        endcase
        if (!req_write) w_wstrb = 4'b0000;
    end

    lsu_load_align #(.DATA_SIZE(DATA_SIZE)) u_align (
        .i_funct3 (r_f3),
        .i_offset (r_addr[1:0]),
        .i_rdata  (mem_rdata),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= 4'b0000;
            r_f3         <= 3'b000;
            r_rd         <= 5'd0;
            r_wb_data    <= '0;
            r_req_ready  <= 1'b1;
            r_mem_req    <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_store_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && w_ok) begin
                        r_we        <= req_write;
                        r_addr      <= w_addr;
                        r_wdata     <= w_wdata;
                        r_wstrb     <= w_wstrb;
                        r_f3        <= req_funct3;
                        r_rd        <= req_rd;
                        r_req_ready <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_state     <= S_BUSY;
                    end else if (req_valid) begin
                        r_err <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        r_wb_data    <= w_load_data;
                        r_mem_req    <= 1'b0;
                        r_wb_valid   <= !r_we;
                        r_store_done <= r_we;
                        r_state      <= S_DONE;
                    end
                end
                default: begin
                    r_wb_valid   <= 1'b0;
                    r_store_done <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr[ADDR_SIZE-1:2];
    assign mem_wdata  = r_wdata;
    assign mem_wstrb  = r_wstrb;
    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_rd;
    assign wb_data    = r_wb_data;
    assign store_done = r_store_done;
    assign access_err = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, errors, reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        store_done;
    logic        access_err;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .store_done (store_done),
        .access_err (access_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single cycle; returns at the next negedge.
    task automatic issue(input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        req_rd     = rd;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic load_op(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] rdata,
                           input logic [4:0] rd, input logic [29:0] exp_addr,
                           input logic [31:0] exp_data);
        issue(1'b0, f3, a, 32'h0, rd);
        chk({tag, " mem_req"}, 64'(mem_req), 64'd1);
        chk({tag, " mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, " mem_addr"}, 64'(mem_addr), 64'(exp_addr));
        chk({tag, " wstrb"}, 64'(mem_wstrb), 64'd0);
        chk({tag, " ready_busy"}, 64'(req_ready), 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk({tag, " wb_valid"}, 64'(wb_valid), 64'd1);
        chk({tag, " wb_data"}, 64'(wb_data), 64'(exp_data));
        chk({tag, " wb_rd"}, 64'(wb_rd), 64'(rd));
        chk({tag, " mem_req_done"}, 64'(mem_req), 64'd0);
        @(negedge clk);
        chk({tag, " wb_valid_end"}, 64'(wb_valid), 64'd0);
        chk({tag, " ready_end"}, 64'(req_ready), 64'd1);
    endtask

    task automatic store_op(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [29:0] exp_addr,
                            input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        issue(1'b1, f3, a, d, 5'd0);
        chk({tag, " mem_req"}, 64'(mem_req), 64'd1);
        chk({tag, " mem_we"}, 64'(mem_we), 64'd1);
        chk({tag, " mem_addr"}, 64'(mem_addr), 64'(exp_addr));
        chk({tag, " wstrb"}, 64'(mem_wstrb), 64'(exp_strb));
        chk({tag, " wdata"}, 64'(mem_wdata), 64'(exp_wdata));
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk({tag, " store_done"}, 64'(store_done), 64'd1);
        chk({tag, " no_wb"}, 64'(wb_valid), 64'd0);
        @(negedge clk);
        chk({tag, " store_done_end"}, 64'(store_done), 64'd0);
    endtask

    task automatic illegal_op(input string tag, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a);
        issue(wr, f3, a, 32'h1234_5678, 5'd4);
        chk({tag, " access_err"}, 64'(access_err), 64'd1);
        chk({tag, " mem_req"}, 64'(mem_req), 64'd0);
        chk({tag, " ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        chk({tag, " access_err_end"}, 64'(access_err), 64'd0);
        chk({tag, " mem_req_end"}, 64'(mem_req), 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;

        #12;
        chk("rst req_ready", 64'(req_ready), 64'd1);
        chk("rst mem_req", 64'(mem_req), 64'd0);
        chk("rst mem_we", 64'(mem_we), 64'd0);
        chk("rst wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst wb_valid", 64'(wb_valid), 64'd0);
        chk("rst wb_rd", 64'(wb_rd), 64'd0);
        chk("rst wb_data", 64'(wb_data), 64'd0);
        chk("rst store_done", 64'(store_done), 64'd0);
        chk("rst access_err", 64'(access_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // SW with ack in the second BUSY cycle
        issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd0);
        chk("sw mem_req c1", 64'(mem_req), 64'd1);
        chk("sw mem_we", 64'(mem_we), 64'd1);
        chk("sw mem_addr", 64'(mem_addr), 64'd4);
        chk("sw wstrb", 64'(mem_wstrb), 64'hF);
        chk("sw wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        @(negedge clk);
        chk("sw mem_req c2", 64'(mem_req), 64'd1);
        chk("sw wdata c2", 64'(mem_wdata), 64'hDEAD_BEEF);
        chk("sw no_done_c2", 64'(store_done), 64'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("sw store_done", 64'(store_done), 64'd1);
        chk("sw mem_req_drop", 64'(mem_req), 64'd0);
        @(negedge clk);
        chk("sw store_done_end", 64'(store_done), 64'd0);
        chk("sw ready", 64'(req_ready), 64'd1);

        load_op("lb", 3'b000, 32'h13, 32'h80FF_0000, 5'd5, 30'd4, 32'hFFFF_FF80);
        load_op("lbu", 3'b100, 32'h13, 32'h80FF_0000, 5'd17, 30'd4, 32'h0000_0080);
        load_op("lb_pos", 3'b000, 32'h11, 32'h0000_7F00, 5'd1, 30'd4, 32'h0000_007F);
        load_op("lh", 3'b001, 32'h02, 32'h8001_1234, 5'd7, 30'd0, 32'hFFFF_8001);
        load_op("lhu", 3'b101, 32'h02, 32'h8001_1234, 5'd8, 30'd0, 32'h0000_8001);
        load_op("lh_lo", 3'b001, 32'h04, 32'h8001_1234, 5'd2, 30'd1, 32'h0000_1234);
        load_op("lw", 3'b010, 32'h08, 32'h1234_5678, 5'd31, 30'd2, 32'h1234_5678);

        store_op("sh", 3'b001, 32'h02, 32'h0000_ABCD, 30'd0, 4'b1100, 32'hABCD_ABCD);
        store_op("sb", 3'b000, 32'h05, 32'h0000_005A, 30'd1, 4'b0010, 32'h5A5A_5A5A);

`ifdef LSU_MISALIGN_TRAP_EN
        illegal_op("lw_mis", 1'b0, 3'b010, 32'h06);
        illegal_op("sh_mis", 1'b1, 3'b001, 32'h03);
`else
        load_op("lw_mis", 3'b010, 32'h06, 32'hCAFE_F00D, 5'd9, 30'd1, 32'hCAFE_F00D);
        store_op("sh_mis", 3'b001, 32'h03, 32'h0000_1357, 30'd0, 4'b1100, 32'h1357_1357);
`endif

        illegal_op("ld_f3_011", 1'b0, 3'b011, 32'h40);
        illegal_op("st_f3_100", 1'b1, 3'b100, 32'h40);

        // Stray acknowledge while idle
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk("idle_ack wb_valid", 64'(wb_valid), 64'd0);
        chk("idle_ack store_done", 64'(store_done), 64'd0);
        chk("idle_ack mem_req", 64'(mem_req), 64'd0);
        chk("idle_ack ready", 64'(req_ready), 64'd1);

        // Reset asserted while BUSY
        issue(1'b0, 3'b010, 32'h20, 32'h0, 5'd3);
        chk("rstbusy mem_req", 64'(mem_req), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstbusy mem_req_async", 64'(mem_req), 64'd0);
        chk("rstbusy ready_async", 64'(req_ready), 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        mem_ack   = 1'b0;
        chk("rstbusy wb_valid", 64'(wb_valid), 64'd0);
        chk("rstbusy wb_data", 64'(wb_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstbusy wb_valid_after", 64'(wb_valid), 64'd0);
        chk("rstbusy store_done_after", 64'(store_done), 64'd0);
        chk("rstbusy ready_after", 64'(req_ready), 64'd1);
        chk("rstbusy mem_req_after", 64'(mem_req), 64'd0);

        load_op("post_rst_lw", 3'b010, 32'h0C, 32'hA5A5_5A5A, 5'd12, 30'd3, 32'hA5A5_5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
